ram_sdp_param: RTL and testbench

- Parametrised simple-dual-port synchronous RAM; next generation of the team's 32x8 single-port RAM.
- One write port and one independent read port, both on the same clock.
- Adds per-byte write enables, selectable read latency, defined read-during-write behaviour and a hardware clear engine that zeroes the array after reset or on request.
- Used as a generic scratch/buffer memory under local controllers.

---
 rtl/ram_sdp_param.sv | 257 +++++++++++++++++++++++++
 tb/tb_ram_sdp_param.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_param.sv
// ---------------------------------------------------------------------------
// ram_sdp_param
//
// Parametrised simple-dual-port synchronous RAM with a single clock domain.
// One write port with per-byte-lane enables and one independent read port.
// Read latency is selectable (1 or 2 cycles after the rd edge). Read-during-
// write to the same address can return the old or the merged new word. A
// small clear engine zeroes the whole array after reset (optional) or on a
// clr pulse. While it runs, user reads and writes are ignored.
//
// Parameters
//   DATA_W        data width, multiple of BYTE_W
//   BYTE_W        byte-lane width covered by one wbe bit
//   ADDR_W        address width
//   DEPTH         number of words, 1 .. 2**ADDR_W
//   RD_LAT        read latency in cycles, 1 or 2
//   RDW_NEW       same-address read-during-write: 0 old data, 1 merged data
//   INIT_ON_RESET 1 starts the clear engine as soon as reset is released
//
// Ports
//   clk         clock, all state changes on the rising edge
//   reset       asynchronous active-high reset (array contents untouched)
//   wr          write request
//   waddr       write address
//   wdata       write data
//   wbe         byte-lane write enables, lane i = wdata[i*BYTE_W +: BYTE_W]
//   rd          read request
//   raddr       read address
//   clr         single-cycle clear request (ignored while clearing)
//   dout        registered read data, holds when dout_valid is low
//   dout_valid  one-cycle pulse marking a new dout
//   busy        clear engine active, user accesses ignored
//
// Out-of-range addresses (>= DEPTH) drop writes and read back as zero with
// dout_valid still asserted.
// ---------------------------------------------------------------------------
module ram_sdp_param #(
    parameter int DATA_W        = 8,
    parameter int BYTE_W        = 8,
    parameter int ADDR_W        = 5,
    parameter int DEPTH         = 32,
    parameter int RD_LAT        = 1,
    parameter int RDW_NEW       = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/BYTE_W-1:0]   wbe,
    input  logic                       rd,
    input  logic [ADDR_W-1:0]          raddr,
    input  logic                       clr,
    output logic [DATA_W-1:0]          dout,
    output logic                       dout_valid,
    output logic                       busy
);

    localparam int                NB        = DATA_W / BYTE_W;
    localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // -----------------------------------------------------------------------
    // Clear engine
    // -----------------------------------------------------------------------
    typedef enum logic {
        S_IDLE = 1'b0,
        S_INIT = 1'b1
    } state_t;

    state_t            state_q;
    logic              busy_q;
    logic [ADDR_W-1:0] clr_addr_q;

    // busy_q is kept as its own register so the busy output comes straight
    // from a flop; it always equals (state_q == S_INIT).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= (INIT_ON_RESET != 0) ? S_INIT : S_IDLE;
            busy_q     <= (INIT_ON_RESET != 0);
            clr_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clr) begin
                        state_q    <= S_INIT;
                        busy_q     <= 1'b1;
                        clr_addr_q <= '0;
                    end
                end
                S_INIT: begin
                    // clr is deliberately not looked at here: a running
                    // clear is never restarted by another request.
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                        clr_addr_q <= '0;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    clr_addr_q <= '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Access qualification
    // -----------------------------------------------------------------------
    logic idle;
    logic waddr_ok;
    logic raddr_ok;
    logic wr_acc;
    logic rd_acc;
    logic rd_hit;

    assign idle     = (state_q == S_IDLE);
    assign waddr_ok = ({1'b0, waddr} < DEPTH_V);
    assign raddr_ok = ({1'b0, raddr} < DEPTH_V);
    assign wr_acc   = idle & wr & waddr_ok;
    assign rd_acc   = idle & rd;
    // Same-address collision that must return merged data on the read side.
    assign rd_hit   = (RDW_NEW != 0) & wr_acc & rd_acc & (waddr == raddr);

    // -----------------------------------------------------------------------
    // Array write port: either the clear engine or the user write.
    // Writes are held off while reset is asserted so that reset never
    // disturbs the stored contents.
    // -----------------------------------------------------------------------
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [NB-1:0]     mem_wbe;
    logic [ADDR_W-1:0] mem_raddr;

    assign mem_we    = ~reset & (~idle | wr_acc);
    assign mem_waddr = idle ? waddr : clr_addr_q;
    assign mem_wdata = idle ? wdata : '0;
    assign mem_wbe   = idle ? wbe   : '1;
    // Out-of-range reads are forced to zero later; clamp the index so the
    // array is never addressed outside its bounds.
    assign mem_raddr = raddr_ok ? raddr : '0;

    // -----------------------------------------------------------------------
    // Read stage 1 side information (valid, out-of-range, bypass)
    // -----------------------------------------------------------------------
    logic              rd_vld1_q;
    logic              rd_oor1_q;
    logic              rd_hit1_q;
    logic [DATA_W-1:0] byp_data1_q;
    logic [NB-1:0]     byp_be1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld1_q   <= 1'b0;
            rd_oor1_q   <= 1'b0;
            rd_hit1_q   <= 1'b0;
            byp_data1_q <= '0;
            byp_be1_q   <= '0;
        end else begin
            rd_vld1_q <= rd_acc;
            if (rd_acc) begin
                rd_oor1_q   <= ~raddr_ok;
                rd_hit1_q   <= rd_hit;
                byp_data1_q <= wdata;
                byp_be1_q   <= wbe;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Storage: one array per byte lane so each lane has a plain
    // write-enable and a registered read, which maps onto block RAM.
    // The read register captures the pre-write contents on a collision;
    // the stage-1 bypass then overlays the written lanes when merged data
    // is wanted.
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] rd_word1;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [BYTE_W-1:0] mem_q [DEPTH];
            logic [BYTE_W-1:0] rdata_q;

            always_ff @(posedge clk) begin
                if (mem_we && mem_wbe[gi]) begin
                    mem_q[mem_waddr] <= mem_wdata[gi*BYTE_W +: BYTE_W];
                end
                if (rd_acc) begin
                    rdata_q <= mem_q[mem_raddr];
                end
            end

            assign rd_word1[gi*BYTE_W +: BYTE_W] =
                rd_oor1_q                   ? '0 :
                (rd_hit1_q && byp_be1_q[gi]) ? byp_data1_q[gi*BYTE_W +: BYTE_W] :
                                               rdata_q;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Optional extra pipeline stage, then the output register
    // -----------------------------------------------------------------------
    logic              dout_valid_d;
    logic [DATA_W-1:0] dout_d;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              rd_vld2_q;
            logic [DATA_W-1:0] rd_word2_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_vld2_q  <= 1'b0;
                    rd_word2_q <= '0;
                end else begin
                    rd_vld2_q <= rd_vld1_q;
                    if (rd_vld1_q) begin
                        rd_word2_q <= rd_word1;
                    end
                end
            end

            assign dout_valid_d = rd_vld2_q;
            assign dout_d       = rd_word2_q;
        end else begin : g_lat1
            assign dout_valid_d = rd_vld1_q;
            assign dout_d       = rd_word1;
        end
    endgenerate

    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= dout_valid_d;
            if (dout_valid_d) begin
                dout_q <= dout_d;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ram_sdp_param.sv
// ---------------------------------------------------------------------------
// tb_ram_sdp_param
//
// Two instances share one stimulus stream:
//   u0 : defaults (8-bit, 32 deep, latency 1, old data on collision)
//   u1 : 32-bit with 4 byte lanes, 20 deep, latency 2, merged data on collision
// A reference model (plain arrays, a countdown for the clear and a
// due-cycle table for read results) predicts busy, dout_valid and dout
// after every rising edge.
// ---------------------------------------------------------------------------
module tb_ram_sdp_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic        wr    = 1'b0;
    logic        rd    = 1'b0;
    logic        clr   = 1'b0;
    logic [4:0]  waddr = '0;
    logic [4:0]  raddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wbe   = '0;

    logic [7:0]  dout0;
    logic        dv0;
    logic        busy0;
    logic [31:0] dout1;
    logic        dv1;
    logic        busy1;

    ram_sdp_param u0 (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr),
        .waddr      (waddr),
        .wdata      (wdata[7:0]),
        .wbe        (wbe[0:0]),
        .rd         (rd),
        .raddr      (raddr),
        .clr        (clr),
        .dout       (dout0),
        .dout_valid (dv0),
        .busy       (busy0)
    );

    ram_sdp_param #(
        .DATA_W        (32),
        .BYTE_W        (8),
        .ADDR_W        (5),
        .DEPTH         (20),
        .RD_LAT        (2),
        .RDW_NEW       (1),
        .INIT_ON_RESET (1)
    ) u1 (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr),
        .waddr      (waddr),
        .wdata      (wdata),
        .wbe        (wbe),
        .rd         (rd),
        .raddr      (raddr),
        .clr        (clr),
        .dout       (dout1),
        .dout_valid (dv1),
        .busy       (busy1)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit verbose  = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int NI = 2;
    int dep  [NI] = '{32, 20};
    int lat  [NI] = '{1, 2};
    int rdwn [NI] = '{0, 1};
    int nb   [NI] = '{1, 4};

    logic [31:0] mdl_mem  [NI][32];
    int          clr_left [NI];
    logic [31:0] exp_dout [NI];
    logic        exp_valid[NI];
    logic        pend_v   [NI][4];
    logic [31:0] pend_d   [NI][4];
    int          cyc = 0;

    function automatic logic [31:0] lane_mask(input int k, input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < nb[k]; b++) begin
            if (be[b]) m[b*8 +: 8] = 8'hFF;
        end
        return m;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            clr_left[k]  = dep[k];
            exp_dout[k]  = '0;
            exp_valid[k] = 1'b0;
            for (int s = 0; s < 4; s++) pend_v[k][s] = 1'b0;
        end
    endtask

    // One rising edge with the currently driven inputs.
    task automatic model_edge();
        if (reset) return;
        cyc++;
        for (int k = 0; k < NI; k++) begin
            logic [31:0] m;
            logic [31:0] r;
            int          slot;
            slot         = cyc % 4;
            exp_valid[k] = pend_v[k][slot];
            if (pend_v[k][slot]) exp_dout[k] = pend_d[k][slot];
            pend_v[k][slot] = 1'b0;
            m = lane_mask(k, wbe);
            if (clr_left[k] > 0) begin
                mdl_mem[k][dep[k] - clr_left[k]] = '0;
                clr_left[k]--;
            end else begin
                if (rd) begin
                    r = (int'(raddr) < dep[k]) ? mdl_mem[k][raddr] : 32'h0;
                    if (rdwn[k] == 1 && wr && waddr == raddr && int'(raddr) < dep[k])
                        r = (r & ~m) | (wdata & m);
                    pend_v[k][(cyc + lat[k]) % 4] = 1'b1;
                    pend_d[k][(cyc + lat[k]) % 4] = r;
                end
                if (wr && int'(waddr) < dep[k])
                    mdl_mem[k][waddr] = (mdl_mem[k][waddr] & ~m) | (wdata & m);
                if (clr) clr_left[k] = dep[k];
            end
        end
    endtask

    task automatic check_outputs();
        check("u0_busy",  32'(busy0), 32'(clr_left[0] > 0));
        check("u0_valid", 32'(dv0),   32'(exp_valid[0]));
        check("u0_dout",  32'(dout0), exp_dout[0]);
        check("u1_busy",  32'(busy1), 32'(clr_left[1] > 0));
        check("u1_valid", 32'(dv1),   32'(exp_valid[1]));
        check("u1_dout",  dout1,      exp_dout[1]);
    endtask

    // ---------------- stimulus helpers ----------------
    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic r, input logic w, input logic [4:0] wa,
                         input logic [4:0] ra, input logic [31:0] wd,
                         input logic [3:0] be, input logic c);
        rd = r; wr = w; waddr = wa; raddr = ra; wdata = wd; wbe = be; clr = c;
        if (verbose)
            $display("cyc %0d rd=%0d ra=%0d wr=%0d wa=%0d wd=%h be=%b clr=%0d rst=%0d",
                     cyc, r, ra, w, wa, wd, be, c, reset);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle_cyc(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic wr_cyc(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        cycle(1'b0, 1'b1, a, 5'd0, d, be, 1'b0);
    endtask

    task automatic rd_cyc(input logic [4:0] a);
        cycle(1'b1, 1'b0, 5'd0, a, 32'h0, 4'h0, 1'b0);
    endtask

    // Asynchronous reset asserted between edges, held for 'hold' edges.
    task automatic do_reset(input int hold);
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        idle_cyc(hold);
        reset = 1'b0;
    endtask

    // Runs 40 cycles from the start of a clear, attempting a write mid-way,
    // and measures how many edges each instance stays busy.
    task automatic busy_window(input string tag);
        int f0, f1;
        f0 = 0; f1 = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) wr_cyc(5'd9, 32'h7777_7777, 4'hF);
            else        idle_cyc(1);
            if (!busy0 && f0 == 0) f0 = i;
            if (!busy1 && f1 == 0) f1 = i;
        end
        check({tag, "_len_u0"}, 32'(f0), 32'd32);
        check({tag, "_len_u1"}, 32'(f1), 32'd20);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        idle_cyc(2);
        reset = 1'b0;
        busy_window("init");

        // reads of a freshly cleared array
        rd_cyc(5'd0); rd_cyc(5'd15); rd_cyc(5'd31);
        idle_cyc(3);

        // byte-lane merge
        wr_cyc(5'd3, 32'hAABB_CCDD, 4'b1111);
        wr_cyc(5'd3, 32'h1122_3344, 4'b0101);
        rd_cyc(5'd3);
        idle_cyc(4);
        check("merge_u0", 32'(dout0), 32'h44);
        check("merge_u1", dout1, 32'hAA22_CC44);

        // read-during-write to the same address
        wr_cyc(5'd7, 32'h55, 4'hF);
        cycle(1'b1, 1'b1, 5'd7, 5'd7, 32'h99, 4'hF, 1'b0);
        idle_cyc(3);
        check("rdw_u0", 32'(dout0), 32'h55);
        check("rdw_u1", dout1, 32'h99);
        rd_cyc(5'd7);
        idle_cyc(3);
        check("rdw_after_u0", 32'(dout0), 32'h99);
        check("rdw_after_u1", dout1, 32'h99);

        // back-to-back reads
        for (int a = 0; a < 4; a++) wr_cyc(5'(a), 32'(8'h10 + a), 4'hF);
        for (int a = 0; a < 4; a++) rd_cyc(5'(a));
        idle_cyc(3);

        // out-of-range on the 20-deep instance
        wr_cyc(5'd5, 32'h5A5A_5A5A, 4'hF);
        wr_cyc(5'd25, 32'hDEAD_BEEF, 4'hF);
        rd_cyc(5'd25);
        idle_cyc(3);
        check("oor_u1", dout1, 32'h0);
        rd_cyc(5'd5);
        idle_cyc(3);
        check("alias_u1", dout1, 32'h5A5A_5A5A);

        // clear after fill, write during clear ignored
        for (int a = 0; a < 32; a++) wr_cyc(5'(a), 32'hFFFF_FFFF, 4'hF);
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 4'h0, 1'b1);
        busy_window("clr");
        for (int a = 0; a < 32; a++) rd_cyc(5'(a));
        idle_cyc(3);

        // reset in the middle of a clear
        for (int a = 0; a < 32; a++) wr_cyc(5'(a), 32'hFFFF_FFFF, 4'hF);
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 4'h0, 1'b1);
        idle_cyc(10);
        do_reset(2);
        busy_window("rst_mid");

        // randomized traffic
        verbose = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            logic [4:0] wa, ra;
            wa = 5'($urandom_range(31));
            ra = ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31));
            if ($urandom_range(299) == 0) begin
                do_reset(1 + $urandom_range(2));
            end else begin
                cycle(1'($urandom), 1'($urandom), wa, ra, $urandom, 4'($urandom),
                      ($urandom_range(149) == 0));
            end
        end

        // final sweep
        verbose = 1'b1;
        idle_cyc(40);
        for (int a = 0; a < 32; a++) rd_cyc(5'(a));
        idle_cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
